// File: rtl/mult8u_rr_sched.sv
// mult8u_rr_sched
//   Shares a single combinational 8x8 unsigned multiplier among NUM_REQ
//   requesters. A round-robin arbiter issues at most one operand pair per
//   cycle into a two-stage pipe (operand regs -> multiplier -> product reg).
//   Results are queued in order in an output FIFO and returned on one
//   valid/ready response port, tagged with the requester id. A credit count
//   (pipe stages in flight + FIFO occupancy) gates issue, so the FIFO can
//   never overflow.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous reset, active low
//   req_valid    per-requester request valid           [NUM_REQ]
//   req_ready    per-requester grant, one-hot or zero   [NUM_REQ]
//   req_a        multiplicands, requester i at [8i+7:8i]
//   req_b        multipliers,   requester i at [8i+7:8i]
//   rsp_valid    FIFO head valid
//   rsp_ready    consumer accepts head
//   rsp_id       requester id of head result            [ID_W]
//   rsp_product  unsigned product of head               [16]
//   stat_issued  transfer counter       (MULT_SCHED_STATS_EN only)
//   stat_stall   stalled-cycle counter  (MULT_SCHED_STATS_EN only)
//
// Configuration
//   MULT_SCHED_STATS_EN  define to add the stat_issued / stat_stall counters.

module mult8u_rr_sched #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int OUT_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*8-1:0] req_a,
    input  logic [NUM_REQ*8-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_product
`ifdef MULT_SCHED_STATS_EN
    ,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_stall
`endif
);

    localparam int PW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW  = $clog2(OUT_DEPTH + 1);
    localparam int CRW = CW + 1;
    localparam int EW  = ID_W + 16;

    // Arbiter state
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic            issue_ok;
    logic            xfer;
    logic [CRW-1:0]  credits;

    // Pipe stage 1: operands
    logic            s1_valid_q, s1_valid_d;
    logic [7:0]      s1_a_q, s1_a_d;
    logic [7:0]      s1_b_q, s1_b_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;

    // Pipe stage 2: product
    logic            s2_valid_q, s2_valid_d;
    logic [15:0]     s2_prod_q, s2_prod_d;
    logic [ID_W-1:0] s2_id_q, s2_id_d;

    logic [15:0]     mult_p;

    // Output FIFO
    logic [EW-1:0]   mem_q [OUT_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            fifo_push;
    logic            fifo_pop;
    logic [EW-1:0]   head;

    // ------------------------------------------------------------------
    // Credit check and round-robin arbitration (combinational)
    // ------------------------------------------------------------------
    always_comb begin
        credits  = CRW'(s1_valid_q) + CRW'(s2_valid_q) + CRW'(count_q);
        // Gating on rst_n keeps req_ready low for the whole reset cycle,
        // before the synchronous reset has cleared the state.
        issue_ok = rst_n && (credits < CRW'(OUT_DEPTH));
    end

    always_comb begin
        int unsigned cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr_q) + k) % NUM_REQ;
            if (!grant_found && (((req_valid >> cand) & NUM_REQ'(1)) != '0)) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_found && issue_ok) begin
            req_ready = NUM_REQ'(1) << grant_idx;
        end
        xfer = grant_found && issue_ok;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Pipe next state
    // ------------------------------------------------------------------
    always_comb begin
        s1_valid_d = xfer;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        if (xfer) begin
            s1_a_d  = 8'(req_a >> {grant_idx, 3'b000});
            s1_b_d  = 8'(req_b >> {grant_idx, 3'b000});
            s1_id_d = grant_idx;
        end
        s2_valid_d = s1_valid_q;
        s2_prod_d  = s2_prod_q;
        s2_id_d    = s2_id_q;
        if (s1_valid_q) begin
            s2_prod_d = mult_p;
            s2_id_d   = s1_id_q;
        end
    end

    mult8u_booth4_ripple u_mult (
        .a_i (s1_a_q),
        .b_i (s1_b_q),
        .p_o (mult_p)
    );

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        rsp_valid   = rst_n && (count_q != '0);
        rsp_id      = rsp_valid ? head[EW-1:16] : '0;
        rsp_product = rsp_valid ? head[15:0]    : '0;
    end

    always_comb begin
        fifo_push = s2_valid_q;
        fifo_pop  = rsp_valid && rsp_ready;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (fifo_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: the head is only visible while count_q != 0.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem_q[wr_ptr_q] <= {s2_id_q, s2_prod_q};
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
            s2_id_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_prod_q  <= s2_prod_d;
            s2_id_q    <= s2_id_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

`ifdef MULT_SCHED_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d;
    logic [31:0] stat_stall_q,  stat_stall_d;

    always_comb begin
        stat_issued_d = stat_issued_q;
        stat_stall_d  = stat_stall_q;
        if (xfer) begin
            stat_issued_d = stat_issued_q + 32'd1;
        end else if (|req_valid) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// mult8u_booth4_ripple
//   Combinational 8x8 unsigned multiplier, 16-bit product. Radix-4 Booth
//   recoding of b (zero-extended so the top digit covers b[7]) gives five
//   partial products, accumulated through ripple-carry adders.
//
// Ports
//   a_i  multiplicand [8]
//   b_i  multiplier   [8]
//   p_o  product      [16]

module mult8u_booth4_ripple (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);

    function automatic logic [17:0] ripple_add(input logic [17:0] x,
                                               input logic [17:0] y);
        logic        c;
        logic [17:0] s;
        c = 1'b0;
        s = '0;
        for (int unsigned i = 0; i < 18; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return s;
    endfunction

    logic [10:0] y_ext;
    logic [17:0] a_ext;
    logic [17:0] pp;
    logic [17:0] acc;
    logic [2:0]  grp;

    always_comb begin
        // Two leading zeros make the recoding treat b as unsigned.
        y_ext = {2'b00, b_i, 1'b0};
        a_ext = {10'b0, a_i};
        acc   = '0;
        pp    = '0;
        grp   = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            grp = 3'(y_ext >> (2 * i));
            case (grp)
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext << 1;
                3'b100:         pp = ~(a_ext << 1) + 18'd1;
                3'b101, 3'b110: pp = ~a_ext + 18'd1;
                default:        pp = '0;
            endcase
            acc = ripple_add(acc, pp << (2 * i));
        end
        p_o = acc[15:0];
    end

endmodule

// File: tb/tb_mult8u_rr_sched.sv
// Directed bench for mult8u_rr_sched (NUM_REQ=4, ID_W=2, OUT_DEPTH=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// following falling edge. A result transferred in the window ending at edge
// E is visible in the window starting after edge E+2.

module tb_mult8u_rr_sched;

    localparam int NUM_REQ   = 4;
    localparam int ID_W      = 2;
    localparam int OUT_DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*8-1:0] req_a;
    logic [NUM_REQ*8-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [15:0]          rsp_product;
`ifdef MULT_SCHED_STATS_EN
    logic [31:0]          stat_issued;
    logic [31:0]          stat_stall;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] cont_prod [4];
    logic [15:0] bp_prod   [5];

    always #5 clk = ~clk;

    mult8u_rr_sched #(
        .NUM_REQ   (NUM_REQ),
        .ID_W      (ID_W),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product)
`ifdef MULT_SCHED_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_stall  (stat_stall)
`endif
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic [15:0] id, input logic [15:0] prod);
        chk({tag, "_valid"},   32'(rsp_valid),   32'd1);
        chk({tag, "_id"},      32'(rsp_id),      32'(id));
        chk({tag, "_product"}, 32'(rsp_product), 32'(prod));
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cont_prod = '{16'd10, 16'd22, 16'd36, 16'd52};
        bp_prod   = '{16'd90, 16'd99, 16'd108, 16'd117, 16'd126};

        // Reset: outputs forced low even with a request pending
        rst_n     = 1'b0;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        @(negedge clk);
        chk("rst_req_ready",   32'(req_ready),   32'd0);
        chk("rst_rsp_valid",   32'(rsp_valid),   32'd0);
        chk("rst_rsp_id",      32'(rsp_id),      32'd0);
        chk("rst_rsp_product", 32'(rsp_product), 32'd0);
        next_cycle();
        next_cycle();
        rst_n     = 1'b1;
        req_valid = '0;
        @(negedge clk);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        next_cycle();

        // Single request: 3*5
        req_valid = 4'b0001;
        set_op(0, 8'd3, 8'd5);
        @(negedge clk);
        chk("single_grant", 32'(req_ready), 32'b0001);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        chk("single_lat1", 32'(rsp_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("single_lat2", 32'(rsp_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk_rsp("single", 16'd0, 16'd15);
        next_cycle();
        @(negedge clk);
        chk("single_drained", 32'(rsp_valid), 32'd0);
        next_cycle();

        // Extremes on requesters 1..3 (pointer is at 1)
        set_op(1, 8'd255, 8'd255);
        set_op(2, 8'd0,   8'd200);
        set_op(3, 8'd128, 8'd2);
        req_valid = 4'b1110;
        @(negedge clk);
        chk("ext_grant1", 32'(req_ready), 32'b0010);
        next_cycle();
        req_valid = 4'b1100;
        @(negedge clk);
        chk("ext_grant2", 32'(req_ready), 32'b0100);
        next_cycle();
        req_valid = 4'b1000;
        @(negedge clk);
        chk("ext_grant3", 32'(req_ready), 32'b1000);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        chk_rsp("ext_255x255", 16'd1, 16'd65025);
        next_cycle();
        @(negedge clk);
        chk_rsp("ext_0x200", 16'd2, 16'd0);
        next_cycle();
        @(negedge clk);
        chk_rsp("ext_128x2", 16'd3, 16'd256);
        next_cycle();
        @(negedge clk);
        chk("ext_drained", 32'(rsp_valid), 32'd0);
        next_cycle();

        // Contention: all four valid for five cycles, pointer at 0
        set_op(0, 8'd1, 8'd10);
        set_op(1, 8'd2, 8'd11);
        set_op(2, 8'd3, 8'd12);
        set_op(3, 8'd4, 8'd13);
        for (int k = 0; k < 8; k++) begin
            req_valid = (k < 5) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            chk("cont_grant", 32'(req_ready), (k < 5) ? (32'd1 << (k % 4)) : 32'd0);
            if (k >= 3) begin
                chk_rsp("cont_rsp", 16'((k - 3) % 4), cont_prod[(k - 3) % 4]);
            end
            next_cycle();
        end
        @(negedge clk);
        chk("cont_drained", 32'(rsp_valid), 32'd0);
        next_cycle();

        // Backpressure: requester 1 always valid, consumer stalled
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            if (k <= 4) set_op(1, 8'(10 + k), 8'd9);
            if (k == 7) rsp_ready = 1'b1;
            @(negedge clk);
            chk("bp_ready", 32'(req_ready), (k < 4) ? 32'b0010 : 32'd0);
            if (k >= 3) begin
                // head stays put while stalled
                chk_rsp("bp_head", 16'd1, bp_prod[0]);
            end
            next_cycle();
        end
        @(negedge clk);
        chk("bp_resume", 32'(req_ready), 32'b0010);
        chk_rsp("bp_rsp1", 16'd1, bp_prod[1]);
        next_cycle();
        req_valid = '0;
        for (int k = 2; k < 5; k++) begin
            @(negedge clk);
            chk_rsp("bp_rsp", 16'd1, bp_prod[k]);
            next_cycle();
        end
        @(negedge clk);
        chk("bp_drained", 32'(rsp_valid), 32'd0);
        next_cycle();

        // Reset mid-operation: 2 in pipe + 2 in FIFO (pointer at 2)
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        set_op(2, 8'd7, 8'd7);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rmo_fill", 32'(req_ready), 32'b0100);
            next_cycle();
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("rmo_rst_rsp_valid",   32'(rsp_valid),   32'd0);
        chk("rmo_rst_rsp_product", 32'(rsp_product), 32'd0);
        chk("rmo_rst_req_ready",   32'(req_ready),   32'd0);
        next_cycle();
        rst_n     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rmo_no_stale", 32'(rsp_valid), 32'd0);
            next_cycle();
        end
        req_valid = 4'b1111;
        set_op(0, 8'd200, 8'd100);
        @(negedge clk);
        chk("rmo_ptr0", 32'(req_ready), 32'b0001);
        next_cycle();
        req_valid = '0;
`ifdef MULT_SCHED_STATS_EN
        @(negedge clk);
        chk("stat_issued", stat_issued, 32'd1);
        chk("stat_stall",  stat_stall,  32'd0);
`endif
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk_rsp("rmo_after", 16'd0, 16'd20000);
        next_cycle();
        @(negedge clk);
        chk("final_drained", 32'(rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
